// File: rtl/ram_n.sv
// Parametrised single-port RAM with a hardware clear sweep after reset.
// Read path is either combinational or a write-first output register.
module ram_n #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int REG_OUT = 0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ld,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic              busy_next;
  logic              clr_we, wr_we;
  logic [WIDTH-1:0]  mem [DEPTH];

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    busy_next  = busy;
    clr_we     = 1'b0;
    wr_we      = 1'b0;
    case (state)
      CLEAR: begin
        clr_we   = 1'b1;
        ptr_next = ptr + ADDR_W'(1);
        if (ptr == LAST) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end
      end
      IDLE:    wr_we = ld;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      busy  <= busy_next;
    end
  end

  // The reset edge itself never writes; user writes are dropped while clearing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[ptr] <= '0;
      end else if (wr_we) begin
        mem[addr] <= in;
      end
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    logic [WIDTH-1:0] rd_p1;

    // Read register: held at zero through the sweep, write-first once idle.
    always_ff @(posedge clk) begin
      if (rst || state == CLEAR) begin
        rd_p1 <= '0;
      end else begin
        rd_p1 <= ld ? in : mem[addr];
      end
    end

    assign out = rd_p1;
  end else begin : g_comb_out
    assign out = (state == CLEAR) ? '0 : mem[addr];
  end

endmodule

// File: tb/tb_ram_n.sv
// Bench for ram_n: a combinational 16x8 instance and a registered 32x64 instance,
// driven with directed and random traffic and scored against a word-level model.
module tb_ram_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b0, ld0 = 1'b0, busy0;
  logic [2:0]  addr0 = '0;
  logic [15:0] in0 = '0, out0;

  logic        rst1 = 1'b0, ld1 = 1'b0, busy1;
  logic [5:0]  addr1 = '0;
  logic [31:0] in1 = '0, out1;

  ram_n #(.WIDTH(16), .DEPTH(8), .REG_OUT(0)) dut0 (
    .clk(clk), .rst(rst0), .in(in0), .addr(addr0), .ld(ld0), .out(out0), .busy(busy0)
  );

  ram_n #(.WIDTH(32), .DEPTH(64), .REG_OUT(1)) dut1 (
    .clk(clk), .rst(rst1), .in(in1), .addr(addr1), .ld(ld1), .out(out1), .busy(busy1)
  );

  typedef struct {
    bit          chk;
    logic        busy;
    logic [31:0] out;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: memory image, cycles of sweep left, registered output.
  logic [31:0] mm [2][64];
  int          rem [2];
  logic [31:0] oreg [2];
  bit          started [2];
  int          cyc [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      rem[d] = 0;
      oreg[d] = '0;
      started[d] = 1'b0;
      cyc[d] = 0;
      for (int i = 0; i < 64; i++) mm[d][i] = '0;
    end
  end

  function automatic int dep(int d);
    return (d == 0) ? 8 : 64;
  endfunction

  function automatic logic [31:0] wmask(int d, logic [31:0] v);
    return (d == 0) ? {16'h0, v[15:0]} : v;
  endfunction

  task automatic step(int d, bit r, bit l, int a, logic [31:0] din);
    exp_t e;
    logic [31:0] dv;
    @(posedge clk);
    #1;
    dv = wmask(d, din);
    a  = a % dep(d);
    if (d == 0) begin
      rst0 = r; ld0 = l; addr0 = 3'(a); in0 = dv[15:0];
    end else begin
      rst1 = r; ld1 = l; addr1 = 6'(a); in1 = dv;
    end
    e.chk  = started[d];
    e.busy = (rem[d] > 0);
    e.cyc  = cyc[d];
    if (d == 1) e.out = oreg[d];
    else        e.out = (rem[d] > 0) ? 32'h0 : mm[d][a];
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    cyc[d]++;
    // effect of the coming edge
    if (r) begin
      started[d] = 1'b1;
      rem[d]     = dep(d);
      oreg[d]    = '0;
    end else if (rem[d] > 0) begin
      rem[d]--;
      oreg[d] = '0;
      if (rem[d] == 0) for (int i = 0; i < 64; i++) mm[d][i] = '0;
    end else begin
      oreg[d] = l ? dv : mm[d][a];
      if (l) mm[d][a] = dv;
    end
  endtask

  task automatic chk(string nm, int d, int c, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL dut%0d %s cycle %0d: got %h, want %h", d, nm, c, got, want);
    end
  endtask

  exp_t em;
  always @(negedge clk) begin
    if (q0.size() > 0) begin
      em = q0.pop_front();
      if (em.chk) begin
        chk("busy", 0, em.cyc, {31'h0, busy0}, {31'h0, em.busy});
        chk("out",  0, em.cyc, {16'h0, out0}, em.out);
      end
    end
    if (q1.size() > 0) begin
      em = q1.pop_front();
      if (em.chk) begin
        chk("busy", 1, em.cyc, {31'h0, busy1}, {31'h0, em.busy});
        chk("out",  1, em.cyc, out1, em.out);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      begin : stim0
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, $urandom_range(7), 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, i, 0);
        step(0, 0, 1, 5, 32'hBEEF);
        step(0, 0, 1, 0, 32'h1234);
        step(0, 0, 0, 5, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 7, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 3, 32'hFFFF);
        step(0, 0, 0, 3, 0);
        step(0, 0, 0, 3, 0);
        for (int i = 4; i < 8; i++) step(0, 0, 1, i, $urandom);
        for (int i = 4; i < 8; i++) step(0, 0, 0, i, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, i, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, $urandom_range(7), $urandom);
        for (int i = 0; i < 8; i++) step(0, 0, 0, i, 0);
        for (int i = 0; i < 300; i++)
          step(0, ($urandom_range(99) == 0), 1'($urandom_range(1)), $urandom_range(7), $urandom);
      end
      begin : stim1
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 64; i++) step(1, 0, 1, $urandom_range(63), $urandom);
        step(1, 0, 1, 63, 32'hA5A5_0001);
        step(1, 0, 0, 63, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 63, 0);
        step(1, 1, 0, 63, 0);
        for (int i = 0; i < 64; i++) step(1, 0, 0, 63, 0);
        step(1, 0, 0, 63, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++)
          step(1, ($urandom_range(149) == 0), 1'($urandom_range(1)), $urandom_range(63), $urandom);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
